// File: rtl/toggle_activity_monitor_if.sv
// rtl/toggle_activity_monitor_if.sv - report word stream between the activity monitor and its consumer
interface toggle_activity_monitor_if #(
  parameter int N_SIG = 7,
  parameter int ACC_W = 32
);
  localparam int IDX_W = $clog2(N_SIG + 1);

  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [ACC_W-1:0] out_data;

  modport master (
    output out_valid,
    output out_idx,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/toggle_activity_monitor.sv
// rtl/toggle_activity_monitor.sv - windowed per-net toggle counter with weighted switching-energy total
module toggle_activity_monitor #(
  parameter int N_SIG   = 7,
  parameter int CNT_W   = 16,
  parameter int W_W     = 8,
  parameter int ACC_W   = 32,
  parameter int WIN_LEN = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N_SIG-1:0]       sig_in,
  input  logic [N_SIG*W_W-1:0]   cap_w,
  output logic                   busy,
  output logic                   done,
  toggle_activity_monitor_if.master rpt
);
  localparam int IDX_W = $clog2(N_SIG + 1);
  localparam int WC_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int SUM_W = W_W + $clog2(N_SIG + 1);
  // One spare bit above the wider operand so acc + sum cannot wrap before the clamp.
  localparam int ADD_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [ACC_W-1:0] ACC_MAX  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SIG);
  localparam logic [WC_W-1:0]  WIN_LAST = WC_W'(WIN_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    COUNT  = 2'd2,
    REPORT = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [N_SIG-1:0]     prev_q;
  logic [N_SIG-1:0]     tog;
  logic [CNT_W-1:0]     cnt [N_SIG];
  logic [ACC_W-1:0]     acc;
  logic [N_SIG*W_W-1:0] w_q;
  logic [WC_W-1:0]      win_cnt;
  logic [IDX_W-1:0]     ptr;
  logic [SUM_W-1:0]     tog_sum;
  logic [ADD_W-1:0]     acc_sum;
  logic                 hs;
  logic                 last_hs;
  logic                 win_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PRIME;
      PRIME:   state_nxt = COUNT;
      COUNT:   if (win_end) state_nxt = REPORT;
      REPORT:  if (last_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state != IDLE);
    rpt.out_valid = (state == REPORT);
    rpt.out_idx   = ptr;
    rpt.out_data  = acc;
    for (int i = 0; i < N_SIG; i++) begin
      if (ptr == IDX_W'(i)) rpt.out_data = ACC_W'(cnt[i]);
    end
  end

  always_comb begin
    hs      = (state == REPORT) && rpt.out_ready;
    last_hs = hs && (ptr == LAST_IDX);
    win_end = (win_cnt == WIN_LAST);
    tog     = sig_in ^ prev_q;
    tog_sum = '0;
    for (int i = 0; i < N_SIG; i++) begin
      if (tog[i]) tog_sum = tog_sum + SUM_W'(w_q[i*W_W +: W_W]);
    end
    acc_sum = ADD_W'(acc) + ADD_W'(tog_sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= '0;
      acc     <= '0;
      w_q     <= '0;
      win_cnt <= '0;
      ptr     <= '0;
      done    <= 1'b0;
      for (int i = 0; i < N_SIG; i++) cnt[i] <= '0;
    end else begin
      done <= last_hs;
      case (state)
        IDLE: begin
          if (start) begin
            acc     <= '0;
            w_q     <= cap_w;
            win_cnt <= '0;
            ptr     <= '0;
            for (int i = 0; i < N_SIG; i++) cnt[i] <= '0;
          end
        end
        PRIME: begin
          prev_q <= sig_in;
        end
        COUNT: begin
          prev_q  <= sig_in;
          win_cnt <= win_cnt + WC_W'(1);
          for (int i = 0; i < N_SIG; i++) begin
            if (tog[i] && (cnt[i] != CNT_MAX)) cnt[i] <= cnt[i] + CNT_W'(1);
          end
          if (acc_sum > ADD_W'(ACC_MAX)) acc <= ACC_MAX;
          else                           acc <= acc_sum[ACC_W-1:0];
        end
        REPORT: begin
          // Pointer wraps to 0 on the energy word so the next window starts clean.
          if (last_hs)  ptr <= '0;
          else if (hs)  ptr <= ptr + IDX_W'(1);
        end
        default: begin
          ptr <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_toggle_activity_monitor.sv
// tb/tb_toggle_activity_monitor.sv - randomized self-checking bench with a behavioural toggle/energy model
module tb_toggle_activity_monitor;
  localparam int  WIN_A  = 8;
  localparam int  CMAX_A = 65535;
  localparam longint AMAX_A = 64'd4294967295;
  localparam int  WIN_B  = 10;
  localparam int  CMAX_B = 7;
  localparam longint AMAX_B = 64'd1023;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [6:0]  sig_a, sig_b;
  logic [55:0] cap_a, cap_b;
  logic        busy_a, busy_b, done_a, done_b;

  int n_checks = 0;
  int n_pass   = 0;
  int n_done_a = 0;
  int stall_idx = -1;
  int stall_len = 0;
  bit rand_stall = 1'b0;
  logic [6:0] samp [11];

  toggle_activity_monitor_if #(.N_SIG(7), .ACC_W(32)) rpt_a ();
  toggle_activity_monitor_if #(.N_SIG(7), .ACC_W(10)) rpt_b ();

  toggle_activity_monitor #(.N_SIG(7), .CNT_W(16), .W_W(8), .ACC_W(32), .WIN_LEN(WIN_A)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .sig_in(sig_a), .cap_w(cap_a),
    .busy(busy_a), .done(done_a), .rpt(rpt_a.master)
  );

  toggle_activity_monitor #(.N_SIG(7), .CNT_W(3), .W_W(8), .ACC_W(10), .WIN_LEN(WIN_B)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .sig_in(sig_b), .cap_w(cap_b),
    .busy(busy_b), .done(done_b), .rpt(rpt_b.master)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done_a === 1'b1) n_done_a++;

  // Reference: toggles are counted between consecutive samples, samp[0] being the PRIME sample.
  function automatic longint exp_cnt(input int win, input int net, input longint cmax);
    longint t = 0;
    for (int k = 1; k <= win; k++) if (samp[k][net] != samp[k-1][net]) t++;
    return (t > cmax) ? cmax : t;
  endfunction

  function automatic longint exp_energy(input int win, input logic [55:0] w, input longint amax);
    longint e = 0;
    for (int k = 1; k <= win; k++)
      for (int n = 0; n < 7; n++)
        if (samp[k][n] != samp[k-1][n]) e += longint'(w[n*8 +: 8]);
    return (e > amax) ? amax : e;
  endfunction

  task automatic gen_rand();
    for (int k = 0; k < 11; k++) samp[k] = 7'($urandom);
  endtask

  task automatic gen_toggler(input int net);
    logic [6:0] base;
    base = 7'($urandom);
    for (int k = 0; k < 11; k++) begin
      samp[k] = base;
      samp[k][net] = k[0];
    end
  endtask

  // Called just after a negedge with DUT A idle; returns on the negedge where done must be high.
  task automatic run_window(input logic [55:0] w, input bit start_busy);
    longint exp_d [8];
    int stall;
    for (int n = 0; n < 7; n++) exp_d[n] = exp_cnt(WIN_A, n, CMAX_A);
    exp_d[7] = exp_energy(WIN_A, w, AMAX_A);
    start_a = 1'b1; cap_a = w; sig_a = 7'($urandom);
    @(negedge clk);
    start_a = 1'b0; cap_a = {$urandom, $urandom} & 56'hFF_FFFF_FFFF_FFFF; sig_a = samp[0];
    n_checks++;
    if (busy_a !== 1'b1) $display("FAIL prime_busy: busy=%b want 1", busy_a); else n_pass++;
    for (int k = 1; k <= WIN_A; k++) begin
      @(negedge clk);
      sig_a = samp[k];
      start_a = start_busy && (k == 3);
      n_checks++;
      if (rpt_a.out_valid !== 1'b0 || busy_a !== 1'b1)
        $display("FAIL count_phase%0d: valid=%b busy=%b want valid=0 busy=1", k, rpt_a.out_valid, busy_a);
      else n_pass++;
    end
    @(negedge clk);
    start_a = 1'b0; sig_a = 7'($urandom);
    for (int idx = 0; idx < 8; idx++) begin
      if (idx == stall_idx) stall = stall_len;
      else if (rand_stall) stall = int'($urandom_range(0, 2));
      else stall = 0;
      start_a = start_busy && (idx == 2);
      rpt_a.out_ready = (stall == 0);
      for (int s = 0; s <= stall; s++) begin
        if (s > 0) @(negedge clk);
        n_checks++;
        if (rpt_a.out_valid !== 1'b1 || rpt_a.out_idx !== 3'(idx) ||
            rpt_a.out_data !== 32'(exp_d[idx]) || done_a !== 1'b0)
          $display("FAIL word%0d_cyc%0d: valid=%b idx=%0d data=%0d done=%b want valid=1 idx=%0d data=%0d done=0",
                   idx, s, rpt_a.out_valid, rpt_a.out_idx, rpt_a.out_data, done_a, idx, exp_d[idx]);
        else n_pass++;
      end
      rpt_a.out_ready = 1'b1;
      @(negedge clk);
    end
    start_a = 1'b0;
    rpt_a.out_ready = 1'($urandom);
    n_checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || rpt_a.out_valid !== 1'b0)
      $display("FAIL finish: done=%b busy=%b valid=%b want 1 0 0", done_a, busy_a, rpt_a.out_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    n_checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || rpt_a.out_valid !== 1'b0)
      $display("FAIL reset_ctrl_a: busy=%b done=%b valid=%b want 0", busy_a, done_a, rpt_a.out_valid);
    else n_pass++;
    n_checks++;
    if (rpt_a.out_idx !== 3'd0 || rpt_a.out_data !== 32'd0)
      $display("FAIL reset_word_a: idx=%0d data=%0d want 0 0", rpt_a.out_idx, rpt_a.out_data);
    else n_pass++;
    n_checks++;
    if (busy_b !== 1'b0 || done_b !== 1'b0 || rpt_b.out_valid !== 1'b0 || rpt_b.out_data !== 10'd0)
      $display("FAIL reset_b: busy=%b done=%b valid=%b data=%0d want 0", busy_b, done_b, rpt_b.out_valid, rpt_b.out_data);
    else n_pass++;
  endtask

  task automatic test_quiet();
    int d0;
    for (int k = 0; k < 11; k++) samp[k] = 7'h55;
    d0 = n_done_a;
    run_window(56'h01_0101_0101_0101, 1'b0);
    @(negedge clk);
    n_checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b0 || n_done_a - d0 !== 1)
      $display("FAIL quiet_done_once: done=%b busy=%b pulses=%0d want 0 0 1", done_a, busy_a, n_done_a - d0);
    else n_pass++;
  endtask

  task automatic test_single_toggler();
    gen_toggler(0);
    run_window({{$urandom, $urandom} & 56'hFF_FFFF_FFFF_FF00} | 56'd3, 1'b0);
  endtask

  task automatic test_backpressure();
    gen_toggler(0);
    stall_idx = 0; stall_len = 3;
    run_window({{$urandom, $urandom} & 56'hFF_FFFF_FFFF_FF00} | 56'd3, 1'b0);
    stall_idx = -1; stall_len = 0;
  endtask

  task automatic test_saturation();
    logic [55:0] w;
    longint exp_d [8];
    gen_toggler(2);
    w = ({$urandom, $urandom} & 56'hFF_FFFF_FF00_FFFF) | 56'h00_0000_00FF_0000;
    for (int n = 0; n < 7; n++) exp_d[n] = exp_cnt(WIN_B, n, CMAX_B);
    exp_d[7] = exp_energy(WIN_B, w, AMAX_B);
    start_b = 1'b1; cap_b = w;
    @(negedge clk);
    start_b = 1'b0; sig_b = samp[0];
    for (int k = 1; k <= WIN_B; k++) begin
      @(negedge clk);
      sig_b = samp[k];
    end
    @(negedge clk);
    rpt_b.out_ready = 1'b1;
    for (int idx = 0; idx < 8; idx++) begin
      n_checks++;
      if (rpt_b.out_valid !== 1'b1 || rpt_b.out_idx !== 3'(idx) || rpt_b.out_data !== 10'(exp_d[idx]))
        $display("FAIL sat_word%0d: valid=%b idx=%0d data=%0d want 1 %0d %0d",
                 idx, rpt_b.out_valid, rpt_b.out_idx, rpt_b.out_data, idx, exp_d[idx]);
      else n_pass++;
      @(negedge clk);
    end
    rpt_b.out_ready = 1'b0;
    n_checks++;
    if (done_b !== 1'b1 || busy_b !== 1'b0)
      $display("FAIL sat_done: done=%b busy=%b want 1 0", done_b, busy_b);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = n_done_a;
    gen_rand();
    start_a = 1'b1; cap_a = {$urandom, $urandom} & 56'hFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    start_a = 1'b0; sig_a = samp[0];
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      sig_a = samp[k];
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (busy_a !== 1'b0 || rpt_a.out_valid !== 1'b0 || done_a !== 1'b0)
      $display("FAIL mid_reset: busy=%b valid=%b done=%b want 0 0 0", busy_a, rpt_a.out_valid, done_a);
    else n_pass++;
    repeat (12) @(negedge clk);
    n_checks++;
    if (n_done_a !== d0 || busy_a !== 1'b0 || rpt_a.out_valid !== 1'b0)
      $display("FAIL mid_reset_quiet: pulses=%0d busy=%b valid=%b want 0 0 0", n_done_a - d0, busy_a, rpt_a.out_valid);
    else n_pass++;
    gen_rand();
    run_window({$urandom, $urandom} & 56'hFF_FFFF_FFFF_FFFF, 1'b0);
  endtask

  task automatic test_start_while_busy();
    int d0;
    d0 = n_done_a;
    gen_rand();
    run_window({$urandom, $urandom} & 56'hFF_FFFF_FFFF_FFFF, 1'b1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (n_done_a - d0 !== 1 || busy_a !== 1'b0 || rpt_a.out_valid !== 1'b0)
      $display("FAIL start_busy_idle: pulses=%0d busy=%b valid=%b want 1 0 0", n_done_a - d0, busy_a, rpt_a.out_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    rand_stall = 1'b1;
    for (int r = 0; r < 3; r++) begin
      gen_rand();
      run_window({$urandom, $urandom} & 56'hFF_FFFF_FFFF_FFFF, 1'b0);
    end
    rand_stall = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    rand_stall = 1'b1;
    for (int r = 0; r < 4; r++) begin
      gen_rand();
      run_window({$urandom, $urandom} & 56'hFF_FFFF_FFFF_FFFF, 1'b0);
      repeat (int'($urandom_range(1, 3))) @(negedge clk);
    end
    rand_stall = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    sig_a = '0; sig_b = '0; cap_a = '0; cap_b = '0;
    rpt_a.out_ready = 1'b0; rpt_b.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_quiet();
    test_single_toggler();
    @(negedge clk);
    test_backpressure();
    @(negedge clk);
    test_saturation();
    @(negedge clk);
    test_reset_mid();
    @(negedge clk);
    test_start_while_busy();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/toggle_activity_monitor.md
# toggle_activity_monitor

Cycle-based switching-activity monitor for the power estimation flow. The stimulus side drives and records waveforms of a design under test; this block consumes that activity. It samples up to N_SIG monitored nets every clock over a programmable window and counts per-net toggles. It accumulates a capacitance-weighted switching-energy figure, then streams the per-net counts and the energy total out over a valid/ready handshake.

## Interface
- N_SIG, 7 — number of monitored nets (for example a, b, c, d, sel[1:0], out).
- CNT_W, 16 — per-net toggle counter width; counters saturate.
- W_W, 8 — per-net capacitance weight width.
- ACC_W, 32 — energy accumulator and output data width; CNT_W ≤ ACC_W.
- WIN_LEN, 32 — number of counting cycles per window; must be ≥ 1.

Ports:
- clk  in  1  — sole clock; all logic is rising-edge.
- rst  in  1  — synchronous, active-high reset.
- start  in  1  — begins a measurement; sampled only in IDLE.
- sig_in  in  N_SIG  — monitored nets; bit i is net i.
- cap_w  in  N_SIG*W_W  — weight of net i in bits [i*W_W +: W_W]; latched on accepted start.
- busy  out  1  — high in every state except IDLE.
- out_valid  out  1  — report word available.
- out_ready  in  1  — consumer accepts the word when out_valid && out_ready.
- out_idx  out  $clog2(N_SIG+1)  — 0..N_SIG-1 selects a net count; N_SIG marks the energy word.
- out_data  out  ACC_W  — zero-extended toggle count, or energy total.
- done  out  1  — one-cycle pulse after the energy word is accepted.

## Operation
- States: IDLE, PRIME, COUNT, REPORT.
- IDLE:
  - When start=1: clear all counters and the accumulator, latch cap_w, go to PRIME.
  - When start=0: stay in IDLE.
- PRIME (1 cycle): register sig_in into prev_q; no counting. Go to COUNT.
- COUNT (exactly WIN_LEN cycles), each cycle:
  - Compute tog = sig_in ^ prev_q.
  - For each i with tog[i]=1, increment cnt[i], saturating at 2^CNT_W-1.
  - Add the sum of cap_w[i] over the toggled nets to acc, saturating at 2^ACC_W-1. The adder is wide enough that the sum never wraps before saturation.
  - Update prev_q to sig_in.
  - After the WIN_LEN-th cycle, go to REPORT with word pointer ptr=0.
- REPORT:
  - Present out_idx=ptr.
  - out_data = cnt[ptr] zero-extended when ptr<N_SIG; acc when ptr=N_SIG.
  - On each handshake, ptr increments.
  - Handshake on ptr=N_SIG: pulse done on the next cycle and return to IDLE.
- start outside IDLE is ignored; it is neither queued nor allowed to restart the measurement.
- sig_in is not sampled outside PRIME and COUNT.

## Timing
- Reset values: busy=0, out_valid=0, out_idx=0, out_data=0, done=0. State is IDLE; all counters, acc, prev_q and latched weights are 0.
- rst at any point, including mid-COUNT or mid-REPORT, aborts the measurement on the next edge. No done is issued and no partial words follow.
- start accepted at edge t: busy=1 from t+1, PRIME at t+1, COUNT from t+2 through t+1+WIN_LEN.
- First out_valid appears in the cycle after the last COUNT cycle.
- Minimum window-to-idle time is WIN_LEN+2+(N_SIG+1) cycles with out_ready held high.
- out_valid is registered:
  - Once asserted, out_valid, out_idx and out_data stay stable until the handshake.
  - Back-to-back words are allowed, one per cycle.
- out_valid never depends combinationally on out_ready.
- done=1 for exactly one cycle, coincident with busy returning to 0. start may be accepted in that same cycle.
- A net that toggles every COUNT cycle yields cnt=WIN_LEN, unless saturated.

## Test plan
- Quiet nets: WIN_LEN=8, all weights 1, sig_in held at 7'h55. Required response: words 0..6 have data 0, word 7 (energy) is 0, done pulses once, busy falls in the same cycle.
- Single toggler: WIN_LEN=8, sig_in[0] inverted every cycle from PRIME on, others constant, cap_w[0]=3. Required response: cnt[0]=8, all other counts 0, energy=24.
- Backpressure: during REPORT, hold out_ready=0 for 3 cycles on word 0 with cnt[0]=8. Required response: out_idx=0 and out_data=8 stay stable throughout, then words 1..7 are accepted one per cycle once ready rises.
- Saturation: CNT_W=3, WIN_LEN=10, net 2 toggling every cycle, cap_w[2]=255, ACC_W=10. Required response: cnt[2]=7 and energy=1023, both saturated.
- Reset mid-operation: assert rst on COUNT cycle 4. Required response: busy=0 and out_valid=0 on the next cycle, no done. A fresh start then reports clean counts with no residue.
- Start while busy: pulse start during COUNT and again during REPORT. Required response: the measurement is unaffected, exactly one done is produced, and the block then sits in IDLE.
